// File: rtl/cva6_region_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cva6_region_pkg
//  Description : Shared types and constants for the runtime-programmable
//                memory-attribute region table.
//  Revision    : 1.0 - initial release
// ============================================================================
package cva6_region_pkg;

    // One region rule. Base and length are held at the widest supported
    // address width and truncated to AddrWidth at the point of use.
    typedef struct packed {
        logic [63:0] base;
        logic [63:0] length;
        logic [7:0]  ctrl;
    } region_rule_t;

    // Field selector carried in cfg_addr_i[1:0]
    localparam logic [1:0] FIELD_BASE   = 2'd0;
    localparam logic [1:0] FIELD_LENGTH = 2'd1;
    localparam logic [1:0] FIELD_CTRL   = 2'd2;
    localparam logic [1:0] FIELD_COMMIT = 2'd3;

    // Ctrl byte bit positions
    localparam int unsigned CTRL_C    = 0;
    localparam int unsigned CTRL_NI   = 1;
    localparam int unsigned CTRL_X    = 2;
    localparam int unsigned CTRL_EN   = 3;
    localparam int unsigned CTRL_LOCK = 7;

    // Bits 6:4 of ctrl are not storable and always read as zero
    localparam logic [7:0] c_ctrl_mask = 8'h8F;

    // Attributes reported on a miss, ordered {X, NI, C}: non-idempotent only
    localparam logic [2:0] c_miss_attr = 3'b010;

    // Build a rule with the non-storable ctrl bits cleared
    function automatic region_rule_t make_rule(input logic [63:0] rule_base,
                                               input logic [63:0] rule_length,
                                               input logic [7:0]  rule_ctrl);
        region_rule_t rule;
        rule.base   = rule_base;
        rule.length = rule_length;
        rule.ctrl   = rule_ctrl & c_ctrl_mask;
        return rule;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cva6_region_match.sv
`default_nettype none
// ============================================================================
//  Module      : cva6_region_match
//  Description : Compares one address against one region rule. Matches when
//                the rule is enabled, addr >= base and (addr - base) < length.
//                A zero length therefore never matches.
//  Revision    : 1.0 - initial release
// ============================================================================
module cva6_region_match #(
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] i_addr,
    input  logic [AddrWidth-1:0] i_base,
    input  logic [AddrWidth-1:0] i_length,
    input  logic                 i_en,
    output logic                 o_match
);

    logic [AddrWidth-1:0] w_offset;

    // Offset computed modulo 2^AddrWidth; the addr >= base term rejects wrap
    assign w_offset = i_addr - i_base;
    assign o_match  = i_en && (i_addr >= i_base) && (w_offset < i_length);

endmodule
`default_nettype wire

// File: rtl/cva6_region_table.sv
`default_nettype none
// ============================================================================
//  Module      : cva6_region_table
//  Description : NrRules programmable memory-attribute rules with shadow /
//                active copies, atomic commit, per-rule lock and a registered
//                lowest-index-wins lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module cva6_region_table
    import cva6_region_pkg::*;
#(
    parameter int unsigned                        NrRules   = 8,
    parameter int unsigned                        AddrWidth = 64,
    parameter logic [NrRules-1:0][AddrWidth-1:0] RstBase   = '0,
    parameter logic [NrRules-1:0][AddrWidth-1:0] RstLength = '0,
    parameter logic [NrRules-1:0][7:0]           RstCtrl   = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [5:0]           cfg_addr_i,
    input  logic [63:0]          cfg_wdata_i,
    output logic [63:0]          cfg_rdata_o,
    output logic                 cfg_rvalid_o,
    output logic                 cfg_err_o,
    input  logic                 lookup_valid_i,
    input  logic [AddrWidth-1:0] lookup_addr_i,
    output logic                 lookup_valid_o,
    output logic                 hit_o,
    output logic [3:0]           hit_idx_o,
    output logic                 cacheable_o,
    output logic                 nonidem_o,
    output logic                 exec_o
);

    region_rule_t r_shadow [NrRules];
    region_rule_t r_active [NrRules];

    logic [3:0]         w_rule_idx;
    logic [1:0]         w_field;
    logic               w_idx_ok;
    logic               w_locked;
    logic               w_err;
    logic               w_wr_ok;
    logic               w_commit;
    logic [63:0]        w_rdata;
    logic               w_unused_ctrl;

    logic [NrRules-1:0] w_match;
    logic               w_hit;
    logic [3:0]         w_hit_idx;
    logic [2:0]         w_attr;

    logic               r_cfg_rvalid;
    logic               r_cfg_err;
    logic [63:0]        r_cfg_rdata;
    logic               r_lookup_valid;
    logic               r_hit;
    logic [3:0]         r_hit_idx;
    logic [2:0]         r_attr;

    assign w_rule_idx = cfg_addr_i[5:2];
    assign w_field    = cfg_addr_i[1:0];
    assign w_idx_ok   = 32'(w_rule_idx) < NrRules;

    // Decode the addressed rule: shadow read data and active lock state
    always_comb begin
        w_locked      = 1'b0;
        w_rdata       = '0;
        w_unused_ctrl = 1'b0;
        for (int i = 0; i < int'(NrRules); i++) begin
            w_unused_ctrl = w_unused_ctrl ^ (^r_active[i].ctrl[6:4]);
            if (w_rule_idx == 4'(i)) begin
                w_locked = r_active[i].ctrl[CTRL_LOCK];
                case (w_field)
                    FIELD_BASE:   w_rdata = r_shadow[i].base;
                    FIELD_LENGTH: w_rdata = r_shadow[i].length;
                    FIELD_CTRL:   w_rdata = 64'(r_shadow[i].ctrl);
                    default:      w_rdata = '0;
                endcase
            end
        end
    end

    // Errors drop the access: bad index, read of commit, write to locked rule
    assign w_err    = !w_idx_ok
                   || (!cfg_we_i && (w_field == FIELD_COMMIT))
                   || ( cfg_we_i && (w_field != FIELD_COMMIT) && w_locked);
    assign w_wr_ok  = cfg_req_i && cfg_we_i && !w_err && (w_field != FIELD_COMMIT);
    assign w_commit = cfg_req_i && cfg_we_i && !w_err && (w_field == FIELD_COMMIT);

    // Shadow updates from config writes; commit copies all shadows to active
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NrRules); i++) begin
                r_shadow[i] <= make_rule(64'(RstBase[i]), 64'(RstLength[i]), RstCtrl[i]);
                r_active[i] <= make_rule(64'(RstBase[i]), 64'(RstLength[i]), RstCtrl[i]);
            end
        end else begin
            for (int i = 0; i < int'(NrRules); i++) begin
                if (w_wr_ok && (w_rule_idx == 4'(i))) begin
                    case (w_field)
                        FIELD_BASE:   r_shadow[i].base   <= 64'(cfg_wdata_i[AddrWidth-1:0]);
                        FIELD_LENGTH: r_shadow[i].length <= 64'(cfg_wdata_i[AddrWidth-1:0]);
                        FIELD_CTRL:   r_shadow[i].ctrl   <= cfg_wdata_i[7:0] & c_ctrl_mask;
                        default:      ;
                    endcase
                end
                if (w_commit) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    // Config response: one-cycle pulse, read data only for successful reads
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cfg_rvalid <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_cfg_rdata  <= '0;
        end else begin
            r_cfg_rvalid <= cfg_req_i;
            r_cfg_err    <= cfg_req_i && w_err;
            r_cfg_rdata  <= (cfg_req_i && !cfg_we_i && !w_err) ? w_rdata : '0;
        end
    end

    for (genvar g = 0; g < NrRules; g++) begin : g_match
        cva6_region_match #(
            .AddrWidth (AddrWidth)
        ) u_match (
            .i_addr   (lookup_addr_i),
            .i_base   (r_active[g].base[AddrWidth-1:0]),
            .i_length (r_active[g].length[AddrWidth-1:0]),
            .i_en     (r_active[g].ctrl[CTRL_EN]),
            .o_match  (w_match[g])
        );
    end

    // Priority encoder: scan downwards so the lowest matching index wins
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_attr    = c_miss_attr;
        for (int i = int'(NrRules) - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit     = 1'b1;
                w_hit_idx = 4'(i);
                w_attr    = {r_active[i].ctrl[CTRL_X], r_active[i].ctrl[CTRL_NI],
                             r_active[i].ctrl[CTRL_C]};
            end
        end
    end

    // Lookup response register; outputs held at zero while no response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lookup_valid <= 1'b0;
            r_hit          <= 1'b0;
            r_hit_idx      <= '0;
            r_attr         <= '0;
        end else begin
            r_lookup_valid <= lookup_valid_i;
            r_hit          <= lookup_valid_i && w_hit;
            r_hit_idx      <= lookup_valid_i ? w_hit_idx : 4'd0;
            r_attr         <= lookup_valid_i ? w_attr    : 3'd0;
        end
    end

    assign cfg_rvalid_o   = r_cfg_rvalid;
    assign cfg_err_o      = r_cfg_err;
    assign cfg_rdata_o    = r_cfg_rdata;
    assign lookup_valid_o = r_lookup_valid;
    assign hit_o          = r_hit;
    assign hit_idx_o      = r_hit_idx;
    assign exec_o         = r_attr[2];
    assign nonidem_o      = r_attr[1];
    assign cacheable_o    = r_attr[0];

endmodule
`default_nettype wire

// File: tb/tb_cva6_region_table.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cva6_region_table
//  Description : Directed self-checking bench for cva6_region_table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cva6_region_table;

    localparam logic [7:0][63:0] c_rst_base   = {{7{64'h0}}, 64'h0000_0000_8000_0000};
    localparam logic [7:0][63:0] c_rst_length = {{7{64'h0}}, 64'h0000_0000_4000_0000};
    localparam logic [7:0][7:0]  c_rst_ctrl   = {{4{8'h00}}, 8'h01, {2{8'h00}}, 8'h0D};

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cfg_req = 1'b0;
    logic        cfg_we = 1'b0;
    logic [5:0]  cfg_addr = '0;
    logic [63:0] cfg_wdata = '0;
    logic [63:0] cfg_rdata;
    logic        cfg_rvalid;
    logic        cfg_err;
    logic        lk_valid_in = 1'b0;
    logic [63:0] lk_addr = '0;
    logic        lk_valid_out;
    logic        hit;
    logic [3:0]  hit_idx;
    logic        cacheable;
    logic        nonidem;
    logic        exec_attr;

    int n_checks = 0;
    int n_errors = 0;

    cva6_region_table #(
        .NrRules   (8),
        .AddrWidth (64),
        .RstBase   (c_rst_base),
        .RstLength (c_rst_length),
        .RstCtrl   (c_rst_ctrl)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .cfg_req_i      (cfg_req),
        .cfg_we_i       (cfg_we),
        .cfg_addr_i     (cfg_addr),
        .cfg_wdata_i    (cfg_wdata),
        .cfg_rdata_o    (cfg_rdata),
        .cfg_rvalid_o   (cfg_rvalid),
        .cfg_err_o      (cfg_err),
        .lookup_valid_i (lk_valid_in),
        .lookup_addr_i  (lk_addr),
        .lookup_valid_o (lk_valid_out),
        .hit_o          (hit),
        .hit_idx_o      (hit_idx),
        .cacheable_o    (cacheable),
        .nonidem_o      (nonidem),
        .exec_o         (exec_attr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One config access; called and returns at posedge+1
    task automatic cfg_access(input logic we, input logic [3:0] idx, input logic [1:0] fld,
                              input logic [63:0] wd, input logic exp_err,
                              input logic [63:0] exp_rd, input string tag);
        cfg_req   = 1'b1;
        cfg_we    = we;
        cfg_addr  = {idx, fld};
        cfg_wdata = wd;
        @(posedge clk); #1;
        cfg_req = 1'b0;
        cfg_we  = 1'b0;
        check({tag, "_rsp"}, {62'd0, cfg_rvalid, cfg_err}, {62'd0, 1'b1, exp_err});
        check({tag, "_rdata"}, cfg_rdata, exp_rd);
    endtask

    task automatic wr(input logic [3:0] idx, input logic [1:0] fld, input logic [63:0] wd,
                      input logic exp_err, input string tag);
        cfg_access(1'b1, idx, fld, wd, exp_err, 64'd0, tag);
    endtask

    task automatic rd(input logic [3:0] idx, input logic [1:0] fld, input logic [63:0] exp,
                      input logic exp_err, input string tag);
        cfg_access(1'b0, idx, fld, 64'd0, exp_err, exp, tag);
    endtask

    // Expected attributes given as {X, NI, C}
    task automatic lookup(input logic [63:0] addr, input logic exp_hit, input logic [3:0] exp_idx,
                          input logic [2:0] exp_attr, input string tag);
        lk_valid_in = 1'b1;
        lk_addr     = addr;
        @(posedge clk); #1;
        lk_valid_in = 1'b0;
        check(tag, {55'd0, lk_valid_out, hit, hit_idx, exec_attr, nonidem, cacheable},
                   {55'd0, 1'b1, exp_hit, exp_idx, exp_attr});
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {55'd0, cfg_rvalid, cfg_err, lk_valid_out, hit, hit_idx, exec_attr,
                    nonidem, cacheable}, 64'd0);
        check({tag, "_rdata"}, cfg_rdata, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 check_quiet("reset_outputs");
        @(negedge clk) rst_ni = 1'b1;
        @(posedge clk); #1;
        check_quiet("post_reset_outputs");

        // Reset rule 0: [0x8000_0000, 0xC000_0000), ctrl 0x0D = EN|X|C
        lookup(64'h8000_1000, 1'b1, 4'd0, 3'b101, "rst_rule0_hit");
        lookup(64'hBFFF_FFFF, 1'b1, 4'd0, 3'b101, "rst_rule0_last");
        lookup(64'hC000_0000, 1'b0, 4'd0, 3'b010, "rst_rule0_end_miss");
        rd(4'd0, 2'd2, 64'h0D, 1'b0, "rst_ctrl0");

        // Shadow writes are invisible until commit
        wr(4'd1, 2'd0, 64'h1_0000, 1'b0, "r1_base");
        wr(4'd1, 2'd1, 64'h1_0000, 1'b0, "r1_len");
        wr(4'd1, 2'd2, 64'h0C, 1'b0, "r1_ctrl");
        rd(4'd1, 2'd2, 64'h0C, 1'b0, "r1_ctrl_rb");
        lookup(64'h1_0004, 1'b0, 4'd0, 3'b010, "r1_precommit_miss");
        wr(4'd6, 2'd2, 64'h70, 1'b0, "r6_ctrl_mask");
        rd(4'd6, 2'd2, 64'h00, 1'b0, "r6_ctrl_mask_rb");
        wr(4'd0, 2'd3, 64'hDEAD, 1'b0, "commit1");
        lookup(64'h1_0004, 1'b1, 4'd1, 3'b100, "r1_commit_hit");
        lookup(64'h2_0000, 1'b0, 4'd0, 3'b010, "r1_end_miss");

        // Overlapping rules 2 and 5, length-0 rule 6, top-of-space rule 7
        wr(4'd2, 2'd0, 64'h0, 1'b0, "r2_base");
        wr(4'd2, 2'd1, 64'h4000, 1'b0, "r2_len");
        wr(4'd2, 2'd2, 64'h09, 1'b0, "r2_ctrl");
        wr(4'd5, 2'd0, 64'h2000, 1'b0, "r5_base");
        wr(4'd5, 2'd1, 64'h1000, 1'b0, "r5_len");
        wr(4'd5, 2'd2, 64'h0A, 1'b0, "r5_ctrl");
        rd(4'd5, 2'd1, 64'h1000, 1'b0, "r5_len_raw");
        wr(4'd6, 2'd0, 64'h5_0000, 1'b0, "r6_base");
        wr(4'd6, 2'd2, 64'h0F, 1'b0, "r6_ctrl");
        wr(4'd7, 2'd0, 64'hFFFF_FFFF_FFFF_F000, 1'b0, "r7_base");
        wr(4'd7, 2'd1, 64'h1000, 1'b0, "r7_len");
        wr(4'd7, 2'd2, 64'h0C, 1'b0, "r7_ctrl");
        wr(4'd3, 2'd3, 64'h0, 1'b0, "commit2");
        lookup(64'h2000, 1'b1, 4'd2, 3'b001, "overlap_low_wins");
        lookup(64'h5_0000, 1'b0, 4'd0, 3'b010, "len0_miss");
        lookup(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd7, 3'b100, "top_hit");
        lookup(64'hFFFF_FFFF_FFFF_EFFF, 1'b0, 4'd0, 3'b010, "top_below_miss");

        // Disable rule 2 so rule 5 wins
        wr(4'd2, 2'd2, 64'h00, 1'b0, "r2_disable");
        wr(4'd2, 2'd3, 64'h0, 1'b0, "commit3");
        lookup(64'h2000, 1'b1, 4'd5, 3'b010, "r5_wins");

        // Lock rule 3; the write in the very next cycle is rejected
        wr(4'd3, 2'd2, 64'h88, 1'b0, "r3_lock_ctrl");
        wr(4'd0, 2'd3, 64'h0, 1'b0, "commit_lock");
        wr(4'd3, 2'd0, 64'h5000, 1'b1, "r3_locked_wr");
        rd(4'd3, 2'd0, 64'h0, 1'b0, "r3_base_unchanged");
        wr(4'd4, 2'd1, 64'h123, 1'b0, "r4_len_wr");
        rd(4'd4, 2'd1, 64'h123, 1'b0, "r4_len_raw");

        // Error cases
        rd(4'd15, 2'd0, 64'h0, 1'b1, "idx15_rd");
        wr(4'd15, 2'd2, 64'h0F, 1'b1, "idx15_wr");
        rd(4'd0, 2'd3, 64'h0, 1'b1, "commit_rd");

        // Lookup coinciding with commit sees the pre-commit rules
        wr(4'd1, 2'd2, 64'h09, 1'b0, "r1_ctrl_new");
        cfg_req     = 1'b1;
        cfg_we      = 1'b1;
        cfg_addr    = {4'd0, 2'd3};
        lk_valid_in = 1'b1;
        lk_addr     = 64'h1_0004;
        @(posedge clk); #1;
        cfg_req     = 1'b0;
        cfg_we      = 1'b0;
        lk_valid_in = 1'b0;
        check("same_cycle_old", {55'd0, lk_valid_out, hit, hit_idx, exec_attr, nonidem, cacheable},
                                {55'd0, 1'b1, 1'b1, 4'd1, 3'b100});
        check("same_cycle_cfg", {62'd0, cfg_rvalid, cfg_err}, {62'd0, 1'b1, 1'b0});
        lookup(64'h1_0004, 1'b1, 4'd1, 3'b001, "post_commit_a");
        lookup(64'h1_FFFF, 1'b1, 4'd1, 3'b001, "post_commit_b");

        // Asynchronous reset mid-operation drops the in-flight response
        lk_valid_in = 1'b1;
        lk_addr     = 64'h8000_0000;
        #2 rst_ni = 1'b0;
        #1 check_quiet("async_reset");
        lk_valid_in = 1'b0;
        @(negedge clk) rst_ni = 1'b1;
        @(posedge clk); #1;
        check_quiet("after_async_reset");
        rd(4'd3, 2'd2, 64'h01, 1'b0, "r3_ctrl_reset");
        wr(4'd3, 2'd0, 64'h5000, 1'b0, "r3_unlocked_wr");
        lookup(64'h1_0004, 1'b0, 4'd0, 3'b010, "r1_reset_miss");
        lookup(64'h8000_1000, 1'b1, 4'd0, 3'b101, "r0_reset_hit");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
